// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between two byte sources:
//   src0 = result output interface, src1 = status/ack reporter.
// A granted source owns the UART for a whole frame. It keeps ownership until
// it reports frame done or until the lock times out. After a release there is
// a short gap, and then ties are broken round-robin. The forwarded start
// pulse and data byte are registered, so they appear one cycle after the
// source's start.
// Build macro TX_ARB_FIXED_PRIO_EN: when defined, src0 always wins a tie in
// IDLE. Frame lock, timeout and gap behaviour are the same in both builds.
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 2_000_000,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  src_tx_start,
  input  logic [15:0] src_tx_data,
  input  logic [1:0]  src_done,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [1:0]  src_busy,
  output logic [1:0]  gnt,
  output logic        arb_timeout
);

  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(LOCK_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]       state;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       pick;
  logic             locked;
  logic             g_start;
  logic             g_done;
  logic             to_hit;
  logic [7:0]       g_byte;

  // Qualify the granted source's start/done pulses; the other source is ignored
  assign locked  = (state == ST_LOCKED);
  assign g_start = locked && |(src_tx_start & gnt);
  assign g_done  = locked && |(src_done & gnt);
  assign g_byte  = gnt[1] ? src_tx_data[15:8] : src_tx_data[7:0];

  // The lock expires on the idle cycle that brings the counter up to the limit
  assign to_next = to_cnt + TO_ONE;
  assign to_hit  = locked && !g_start && !tx_busy && (to_next == TO_LIMIT);

`ifdef TX_ARB_FIXED_PRIO_EN
  // Fixed priority: src0 wins any tie, history is not tracked
  always_comb begin
    pick = 2'b00;
    if (req[0]) begin
      pick = 2'b01;
    end else if (req[1]) begin
      pick = 2'b10;
    end
  end
`else
  logic last_gnt;

  // Round-robin: on a tie, grant the source that did not win last time
  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  // Remember the most recent winner; starts at src1 so src0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if ((state == ST_IDLE) && (|req)) begin
      last_gnt <= pick[1];
    end
  end
`endif

  // Frame-lock sequencer: IDLE grants, LOCKED holds, RELEASE enforces the gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= 2'b00;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt   <= pick;
            state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (g_done) begin
            gnt   <= 2'b00;
            state <= ST_RELEASE;
          end else if (to_hit) begin
            arb_timeout <= 1'b1;
            gnt         <= 2'b00;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          gnt   <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Lock timeout counter: only runs in LOCKED, cleared by any sign of activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!locked || g_start || tx_busy) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIMIT) begin
      to_cnt <= to_next;
    end
  end

  // Gap counter: counts the cycles spent in RELEASE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == ST_RELEASE) begin
      gap_cnt <= gap_cnt + GAP_ONE;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Register the granted source's start and byte towards the UART core
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= g_start;
      if (g_start) begin
        tx_data <= g_byte;
      end
    end
  end

  // Busy back to the sources: only the granted one can see the UART free
  always_comb begin
    src_busy = 2'b11;
    if (gnt[0]) begin
      src_busy[0] = tx_busy | tx_start;
    end
    if (gnt[1]) begin
      src_busy[1] = tx_busy | tx_start;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Drives whole frames from a transaction-level model of the arbiter.
// Expected grants, releases and forwarded bytes are scheduled in absolute
// cycle numbers, and a separate monitor pops and compares them.
module tb_uart_tx_arbiter;

  localparam int LT  = 10;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  src_tx_start;
  logic [15:0] src_tx_data;
  logic [1:0]  src_done;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  src_busy;
  logic [1:0]  gnt;
  logic        arb_timeout;

  uart_tx_arbiter #(.LOCK_TIMEOUT(LT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .src_tx_start(src_tx_start),
    .src_tx_data(src_tx_data), .src_done(src_done), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .src_busy(src_busy),
    .gnt(gnt), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_byte_cyc[$];
  int exp_byte_val[$];
  int exp_gnt_cyc[$];
  int exp_gnt_src[$];
  int exp_rel_cyc[$];
  int exp_rel_to[$];

  logic [1:0] model_gnt  = 2'b00;
  int         model_last = 1;
  int         idle_from  = 0;
  int         exp_timeouts  = 0;
  int         seen_timeouts = 0;
  logic       mon_en   = 1'b0;
  logic [1:0] prev_gnt = 2'b00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's worth of inputs, then move to the next cycle
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] st, input logic [15:0] d,
                               input logic [1:0] dn, input logic b);
    req = r; src_tx_start = st; src_tx_data = d; src_done = dn; tx_busy = b;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] pack(input int g, input logic [7:0] b);
    return (g == 1) ? {b, 8'hAA} : {8'hAA, b};
  endfunction

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef TX_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (model_last == 0) ? 1 : 0;
`endif
  endfunction

  // kind 0: ends with done; kind 1: lock timeout; kind 2: done on the timeout cycle
  task automatic run_frame(input int kind, input logic [1:0] force_pat);
    logic [1:0] pat, gbit, obit, st, dn;
    logic [7:0] b;
    logic       busy;
    int g, gc, last_act, nb, fire, rel;
    pat = (force_pat != 2'b00) ? force_pat : 2'($urandom_range(1, 3));
    repeat ($urandom_range(0, 2)) applyStimulus(2'b00, 2'b00, 16'h0, 2'b00, 1'b0);
    g = pick(pat);
    model_last = g;
    gc = ((cyc > idle_from) ? cyc : idle_from) + 1;
    exp_gnt_cyc.push_back(gc);
    exp_gnt_src.push_back(g);
    while (cyc < gc) applyStimulus(pat, 2'b00, 16'h0, 2'b00, 1'b0);
    model_gnt = 2'(1 << g);
    gbit = 2'(1 << g);
    obit = ~gbit;
    last_act = gc - 1;
    nb = (kind == 0) ? $urandom_range(0, 4) : $urandom_range(0, 2);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 3)) begin
        busy = (kind == 0) && ($urandom_range(0, 2) == 0);
        st = ($urandom_range(0, 3) == 0) ? obit : 2'b00;
        dn = ($urandom_range(0, 4) == 0) ? obit : 2'b00;
        if (busy) last_act = cyc;
        applyStimulus(2'($urandom), st, pack(g, 8'h00), dn, busy);
      end
      b = 8'($urandom);
      busy = (kind == 0) && ($urandom_range(0, 2) == 0);
      st = gbit | (($urandom_range(0, 1) == 1) ? obit : 2'b00);
      exp_byte_cyc.push_back(cyc + 1);
      exp_byte_val.push_back(int'(b));
      last_act = cyc;
      applyStimulus(2'($urandom), st, pack(g, b), 2'b00, busy);
    end
    if (kind == 0) begin
      repeat ($urandom_range(0, 2)) applyStimulus(2'($urandom), 2'b00, 16'h0, 2'b00, 1'($urandom));
      b = 8'($urandom);
      st = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        st = gbit;
        exp_byte_cyc.push_back(cyc + 1);
        exp_byte_val.push_back(int'(b));
      end
      rel = cyc + 1;
      exp_rel_cyc.push_back(rel);
      exp_rel_to.push_back(0);
      applyStimulus(2'($urandom), st, pack(g, b), gbit | (($urandom_range(0, 1) == 1) ? obit : 2'b00), 1'b0);
    end else begin
      fire = last_act + LT;
      while (cyc < fire) begin
        st = ($urandom_range(0, 2) == 0) ? obit : 2'b00;
        applyStimulus(2'($urandom), st, pack(g, 8'h00), 2'b00, 1'b0);
      end
      rel = fire + 1;
      exp_rel_cyc.push_back(rel);
      if (kind == 1) begin
        exp_rel_to.push_back(1);
        exp_timeouts++;
        applyStimulus(2'($urandom), 2'b00, 16'h0, 2'b00, 1'b0);
      end else begin
        exp_rel_to.push_back(0);
        applyStimulus(2'($urandom), 2'b00, 16'h0, gbit, 1'b0);
      end
    end
    model_gnt = 2'b00;
    idle_from = rel + GAP;
    applyStimulus(2'b00, 2'($urandom), 16'h5A5A, 2'($urandom), 1'b0);
  endtask

  // Monitor: compares DUT outputs against the scheduled expectations
  always @(negedge clk) begin
    int c, d;
    logic [1:0] eb;
    logic       txs;
    if (reset) begin
      prev_gnt = 2'b00;
    end else if (mon_en) begin
      txs = (exp_byte_cyc.size() > 0) && (exp_byte_cyc[0] == cyc);
      eb = 2'b11;
      for (int i = 0; i < 2; i++) if (model_gnt[i]) eb[i] = tx_busy | txs;
      checkOutput("src_busy", 32'(src_busy), 32'(eb));
      if ((exp_byte_cyc.size() > 0) && (txs || tx_start)) begin
        c = exp_byte_cyc.pop_front();
        d = exp_byte_val.pop_front();
        checkOutput("tx_start_pulse", 32'(tx_start), 32'd1);
        checkOutput("tx_start_cycle", cyc, c);
        checkOutput("tx_data", 32'(tx_data), d);
      end else if (tx_start) begin
        checkOutput("spurious_tx_start", 32'(tx_start), 32'd0);
      end
      if (gnt != prev_gnt) begin
        if (prev_gnt != 2'b00) begin
          checkOutput("release_gnt", 32'(gnt), 32'd0);
          if (exp_rel_cyc.size() > 0) begin
            c = exp_rel_cyc.pop_front();
            d = exp_rel_to.pop_front();
            checkOutput("release_cycle", cyc, c);
            checkOutput("arb_timeout", 32'(arb_timeout), d);
          end else begin
            checkOutput("spurious_release", 32'(gnt), 32'(prev_gnt));
          end
        end
        if (gnt != 2'b00) begin
          if (exp_gnt_cyc.size() > 0) begin
            c = exp_gnt_cyc.pop_front();
            d = exp_gnt_src.pop_front();
            checkOutput("gnt_value", 32'(gnt), 32'(1 << d));
            checkOutput("gnt_cycle", cyc, c);
          end else begin
            checkOutput("spurious_grant", 32'(gnt), 32'd0);
          end
        end
      end
      if (arb_timeout) seen_timeouts++;
      prev_gnt = gnt;
    end
  end

  // Reset asserted between the 2nd and 3rd byte of a src0 frame
  task automatic reset_mid_frame();
    int gc;
    while (cyc < idle_from) applyStimulus(2'b00, 2'b00, 16'h0, 2'b00, 1'b0);
    model_last = 0;
    gc = cyc + 1;
    exp_gnt_cyc.push_back(gc);
    exp_gnt_src.push_back(0);
    applyStimulus(2'b01, 2'b00, 16'h0, 2'b00, 1'b0);
    model_gnt = 2'b01;
    for (int i = 0; i < 2; i++) begin
      exp_byte_cyc.push_back(cyc + 1);
      exp_byte_val.push_back(32'h31 + i);
      applyStimulus(2'b01, 2'b01, pack(0, 8'(8'h31 + i)), 2'b00, 1'b0);
      applyStimulus(2'b01, 2'b00, 16'h0, 2'b00, 1'b0);
    end
    #1 reset = 1'b1;
    model_gnt = 2'b00;
    #1;
    checkOutput("midreset_gnt", 32'(gnt), 32'd0);
    checkOutput("midreset_tx_start", 32'(tx_start), 32'd0);
    checkOutput("midreset_tx_data", 32'(tx_data), 32'd0);
    checkOutput("midreset_src_busy", 32'(src_busy), 32'd3);
    checkOutput("midreset_arb_timeout", 32'(arb_timeout), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_last = 1;
    idle_from = 0;
    run_frame(0, 2'b01);
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00; src_tx_start = 2'b00; src_tx_data = 16'h0; src_done = 2'b00; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset_arb_timeout", 32'(arb_timeout), 32'd0);
    checkOutput("reset_src_busy", 32'(src_busy), 32'd3);
    reset = 1'b0;
    mon_en = 1'b1;
    run_frame(0, 2'b11);
    run_frame(0, 2'b11);
    run_frame(0, 2'b11);
    run_frame(1, 2'b01);
    run_frame(0, 2'b11);
    run_frame(2, 2'b10);
    for (int i = 0; i < 40; i++) run_frame($urandom_range(0, 2), 2'b00);
    reset_mid_frame();
    repeat (4) applyStimulus(2'b00, 2'b00, 16'h0, 2'b00, 1'b0);
    checkOutput("pending_bytes", exp_byte_cyc.size(), 32'd0);
    checkOutput("pending_grants", exp_gnt_cyc.size(), 32'd0);
    checkOutput("pending_releases", exp_rel_cyc.size(), 32'd0);
    checkOutput("timeout_pulses", seen_timeouts, exp_timeouts);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
